mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multi-cycle control state machine that sequences fetch, decode, execute, memory and writeback for the RV32I subset. It drives the operand-select and ALU-op-select lines that feed the ALU, and it consumes the ALU's alu_bcond. It also generates PC, IR, register-file and memory strobes. The block sits directly upstream of the ALU/ALU-control path in the multi-cycle datapath.

Parameters:
HALT_ON_ECALL, 1, 1: ECALL enters HALT; 0: ECALL is retired as a NOP (PC+4).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
opcode  input  7  IR[6:0], stable from ID onward
alu_bcond  input  1  branch condition from ALU, combinational
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  load PC this cycle
pc_source  output  1  0 = PC from ALU result, 1 = PC from ALUOut register
ir_write  output  1  latch instruction into IR
i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_to_reg  output  1  RF write data: 0 = ALUOut, 1 = MDR
reg_write  output  1  RF write enable
alu_src_a  output  1  0 = PC, 1 = A register (rs1)
alu_src_b  output  2  00 = B register (rs2), 01 = constant 4, 10 = immediate
alu_op_sel  output  1  0 = force ADD op to ALU, 1 = op decoded from funct fields
inst_done  output  1  one-cycle pulse when an instruction retires (coincides with pc_write)
halted  output  1  sticky, set in HALT
state  output  3  current state, for debug

Behaviour:
- State encoding: IF=0, ID=1, EX=2, BR=3, MEM=4, WB=5, HALT=6. Codes 7 and above go to IF on the next edge.
- Reset: when reset==0 at an edge, state becomes IF and halted becomes 0. While reset==0, all control outputs are forced to 0.
- Outputs are combinational from state, opcode, alu_bcond and mem_ready. Every output not listed for a state is 0.
- Opcodes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, ECALL=1110011. Any other opcode is illegal.
- IF:
  - mem_read=1, i_or_d=0, ir_write=mem_ready.
  - Next state: ID if mem_ready, else IF. IR is written exactly once per fetch.
- ID:
  - alu_src_a=0, alu_src_b=01, alu_op_sel=0, so ALUOut <= PC+4.
  - Next state: EX for all opcodes, except ECALL with HALT_ON_ECALL=1, which goes to HALT.
- EX:
  - R: a=1, b=00, op_sel=1. Next WB.
  - I: a=1, b=10, op_sel=1. Next WB.
  - LOAD/STORE: a=1, b=10, op_sel=0. Next MEM.
  - BRANCH: a=1, b=00, op_sel=1.
    - alu_bcond=1: next BR.
    - alu_bcond=0: pc_write=1, pc_source=1 (PC <= PC+4), inst_done=1, next IF.
  - JAL: a=0, b=10, op_sel=0, pc_write=1, pc_source=0, reg_write=1, mem_to_reg=0 (rd <= PC+4), inst_done=1. Next IF.
  - JALR: as JAL but a=1.
  - Illegal opcode, or ECALL with HALT_ON_ECALL=0: next WB.
- BR: a=0, b=10, op_sel=0, pc_write=1, pc_source=0, inst_done=1. Next IF.
- MEM:
  - i_or_d=1. mem_read=1 for LOAD; mem_write=1 for STORE.
  - Stay in MEM while mem_ready=0; go to WB when mem_ready=1.
  - mem_write is held high for the whole wait.
- WB:
  - a=0, b=01, op_sel=0, pc_write=1, pc_source=0 (PC <= PC+4), inst_done=1.
  - reg_write=1 only for R, I and LOAD; mem_to_reg=1 only for LOAD.
  - Next IF.
- HALT: all strobes 0, halted=1. Remain in HALT until reset.
- Cycle counts with mem_ready held at 1:
  - R/I: 4 cycles.
  - LOAD/STORE: 5 cycles.
  - Branch not taken: 3 cycles; branch taken: 4 cycles.
  - JAL/JALR: 3 cycles.
  - Each memory wait cycle adds 1.
- Reset mid-operation (any state, including a MEM wait): the next state is IF, and no strobe is asserted during the reset cycle.

Test Plan:
- R-type (0110011), mem_ready=1 -> states 0,1,2,5. reg_write=1 and pc_write=1 only in WB. Exactly one inst_done over 4 cycles.
- LOAD with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_read=1, i_or_d=1. Then WB with mem_to_reg=1, reg_write=1. Total 7 cycles.
- BRANCH with alu_bcond=0 -> EX asserts pc_write=1, pc_source=1, returns to IF after 3 cycles. With alu_bcond=1 -> BR asserts pc_write=1, pc_source=0, alu_src_b=10. Total 4 cycles.
- JAL -> in EX, pc_write=1, reg_write=1, mem_to_reg=0, alu_src_a=0, alu_src_b=10. Next state IF.
- ECALL with HALT_ON_ECALL=1 -> ID goes to HALT; halted=1 and all strobes stay 0 for 10+ cycles. reset=0 for one edge -> state=IF, halted=0.
- STORE with reset driven to 0 during the MEM wait -> mem_write=0 in that cycle, state=IF next cycle, and no inst_done pulse.

Source files
------------

// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle control FSM and the RV32I datapath.
// The FSM is the master: it reads opcode, branch condition and memory ready, and drives every strobe.
interface mc_control_if;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_source;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       alu_op_sel;
  logic       inst_done;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  opcode, alu_bcond, mem_ready,
    output pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op_sel,
           inst_done, halted, state
  );

  modport slave (
    output opcode, alu_bcond, mem_ready,
    input  pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op_sel,
           inst_done, halted, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/BR/MEM/WB/HALT.
// Strobes are decoded combinationally from state and live inputs, so IR/MEM handshakes react in the same cycle.
module mc_control_fsm #(
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_BR   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t state_q;
  state_t state_nxt;
  logic   halted_q;

  always_comb begin
    state_nxt          = S_IF;
    bus.pc_write       = 1'b0;
    bus.pc_source      = 1'b0;
    bus.ir_write       = 1'b0;
    bus.i_or_d         = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_to_reg     = 1'b0;
    bus.reg_write      = 1'b0;
    bus.alu_src_a      = 1'b0;
    bus.alu_src_b      = 2'b00;
    bus.alu_op_sel     = 1'b0;
    bus.inst_done      = 1'b0;
    case (state_q)
      S_IF: begin
        bus.mem_read = 1'b1;
        bus.ir_write = bus.mem_ready;
        state_nxt    = bus.mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        bus.alu_src_b = 2'b01;
        state_nxt     = (HALT_ON_ECALL && bus.opcode == OP_ECALL) ? S_HALT : S_EX;
      end
      S_EX: begin
        case (bus.opcode)
          OP_R: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_op_sel = 1'b1;
            state_nxt      = S_WB;
          end
          OP_I: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_src_b  = 2'b10;
            bus.alu_op_sel = 1'b1;
            state_nxt      = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            state_nxt     = S_MEM;
          end
          OP_BRANCH: begin
            bus.alu_src_a  = 1'b1;
            bus.alu_op_sel = 1'b1;
            if (bus.alu_bcond) begin
              state_nxt = S_BR;
            end else begin
              // Not taken: ALUOut still holds PC+4 from ID.
              bus.pc_write  = 1'b1;
              bus.pc_source = 1'b1;
              bus.inst_done = 1'b1;
              state_nxt     = S_IF;
            end
          end
          OP_JAL, OP_JALR: begin
            bus.alu_src_a = (bus.opcode == OP_JALR);
            bus.alu_src_b = 2'b10;
            bus.pc_write  = 1'b1;
            bus.reg_write = 1'b1;
            bus.inst_done = 1'b1;
            state_nxt     = S_IF;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_BR: begin
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        bus.inst_done = 1'b1;
        state_nxt     = S_IF;
      end
      S_MEM: begin
        bus.i_or_d    = 1'b1;
        bus.mem_read  = (bus.opcode == OP_LOAD);
        bus.mem_write = (bus.opcode == OP_STORE);
        state_nxt     = bus.mem_ready ? S_WB : S_MEM;
      end
      S_WB: begin
        bus.alu_src_b  = 2'b01;
        bus.pc_write   = 1'b1;
        bus.inst_done  = 1'b1;
        bus.reg_write  = (bus.opcode == OP_R) || (bus.opcode == OP_I) || (bus.opcode == OP_LOAD);
        bus.mem_to_reg = (bus.opcode == OP_LOAD);
        state_nxt      = S_IF;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
    // An asserted reset overrides any strobe the current state would drive.
    if (!reset) begin
      bus.pc_write   = 1'b0;
      bus.pc_source  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_op_sel = 1'b0;
      bus.inst_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      halted_q <= halted_q | (state_nxt == S_HALT);
    end
  end

  assign bus.halted = halted_q & reset;
  assign bus.state  = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: per-instruction phase model, retire timing and strobe totals.
module tb_mc_control_fsm;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_BR = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  mc_control_if bus ();
  mc_control_if bus0 ();

  assign bus0.opcode    = bus.opcode;
  assign bus0.alu_bcond = bus.alu_bcond;
  assign bus0.mem_ready = bus.mem_ready;

  mc_control_fsm #(.HALT_ON_ECALL(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mc_control_fsm #(.HALT_ON_ECALL(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  function automatic logic [12:0] strobes();
    return {bus.pc_write, bus.pc_source, bus.ir_write, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op_sel, bus.inst_done};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from its first IF cycle to its retire cycle.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bc);
    logic [2:0] exp_q[$];
    logic       rdy_q[$];
    bit is_ls, writes_rd, not_taken, jump;
    int n, done_at, exp_cycles;
    int n_rw, n_m2r, n_mr, n_mw;
    logic [1:0] exp_b;
    is_ls     = (op == OP_LOAD) || (op == OP_STORE);
    jump      = (op == OP_JAL) || (op == OP_JALR);
    not_taken = (op == OP_BRANCH) && !bc;
    writes_rd = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || jump;
    for (int k = 0; k <= fw; k++) begin exp_q.push_back(ST_IF); rdy_q.push_back(k == fw); end
    exp_q.push_back(ST_ID); rdy_q.push_back(1'($urandom_range(0, 1)));
    exp_q.push_back(ST_EX); rdy_q.push_back(1'($urandom_range(0, 1)));
    if (is_ls)
      for (int k = 0; k <= mw; k++) begin exp_q.push_back(ST_MEM); rdy_q.push_back(k == mw); end
    if (op == OP_BRANCH) begin
      if (bc) begin exp_q.push_back(ST_BR); rdy_q.push_back(1'($urandom_range(0, 1))); end
    end else if (!jump) begin
      exp_q.push_back(ST_WB); rdy_q.push_back(1'($urandom_range(0, 1)));
    end
    if (is_ls) exp_cycles = 5 + fw + mw;
    else if (op == OP_BRANCH) exp_cycles = bc ? 4 + fw : 3 + fw;
    else if (jump) exp_cycles = 3 + fw;
    else exp_cycles = 4 + fw;
    exp_b = not_taken ? 2'b00 : ((jump || op == OP_BRANCH) ? 2'b10 : 2'b01);
    n = exp_q.size();
    done_at = -1;
    n_rw = 0; n_m2r = 0; n_mr = 0; n_mw = 0;
    bus.opcode    = op;
    bus.alu_bcond = bc;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = rdy_q[i];
      @(negedge clk);
      checks++;
      if (bus.state !== exp_q[i]) begin
        errors++;
        $display("FAIL state op=%b cyc=%0d: got %0d expected %0d", op, i, bus.state, exp_q[i]);
      end
      checks++;
      if ({bus.pc_write, bus.inst_done} !== {2{i == n - 1}}) begin
        errors++;
        $display("FAIL retire op=%b cyc=%0d: got pc_write,inst_done=%b expected %b", op, i,
                 {bus.pc_write, bus.inst_done}, {2{i == n - 1}});
      end
      checks++;
      if (bus.ir_write !== (i == fw)) begin
        errors++;
        $display("FAIL ir_write op=%b cyc=%0d: got %b expected %b", op, i, bus.ir_write, i == fw);
      end
      checks++;
      if (bus.i_or_d !== (exp_q[i] == ST_MEM)) begin
        errors++;
        $display("FAIL i_or_d op=%b cyc=%0d: got %b expected %b", op, i, bus.i_or_d, exp_q[i] == ST_MEM);
      end
      if (bus.inst_done === 1'b1 && done_at < 0) done_at = i;
      n_rw  += int'(bus.reg_write === 1'b1);
      n_m2r += int'(bus.mem_to_reg === 1'b1);
      n_mr  += int'(bus.mem_read === 1'b1);
      n_mw  += int'(bus.mem_write === 1'b1);
      if (i == n - 1) begin
        checks++;
        if ({bus.pc_source, bus.alu_src_b} !== {not_taken, exp_b}) begin
          errors++;
          $display("FAIL retire_mux op=%b: got pc_source,alu_src_b=%b expected %b", op,
                   {bus.pc_source, bus.alu_src_b}, {not_taken, exp_b});
        end
        checks++;
        if ({bus.alu_src_a, bus.alu_op_sel} !== {(op == OP_JALR) || not_taken, not_taken}) begin
          errors++;
          $display("FAIL retire_alu op=%b: got alu_src_a,alu_op_sel=%b expected %b", op,
                   {bus.alu_src_a, bus.alu_op_sel}, {(op == OP_JALR) || not_taken, not_taken});
        end
      end
      next_cycle();
    end
    checks++;
    if (done_at + 1 !== exp_cycles) begin
      errors++;
      $display("FAIL cycles op=%b fw=%0d mw=%0d: got %0d expected %0d", op, fw, mw, done_at + 1, exp_cycles);
    end
    checks++;
    if (n_rw !== int'(writes_rd) || n_m2r !== int'(op == OP_LOAD)) begin
      errors++;
      $display("FAIL rf_writes op=%b: got reg_write=%0d mem_to_reg=%0d expected %0d %0d", op,
               n_rw, n_m2r, int'(writes_rd), int'(op == OP_LOAD));
    end
    checks++;
    if (n_mr !== fw + 1 + ((op == OP_LOAD) ? mw + 1 : 0) || n_mw !== ((op == OP_STORE) ? mw + 1 : 0)) begin
      errors++;
      $display("FAIL mem_strobes op=%b: got mem_read=%0d mem_write=%0d expected %0d %0d", op, n_mr, n_mw,
               fw + 1 + ((op == OP_LOAD) ? mw + 1 : 0), (op == OP_STORE) ? mw + 1 : 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.alu_bcond = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.opcode = 7'($urandom);
      next_cycle();
      @(negedge clk);
      checks++;
      if ({bus.state, bus.halted, strobes()} !== 17'd0) begin
        errors++;
        $display("FAIL reset_outputs: got state=%0d halted=%b strobes=%b expected all 0",
                 bus.state, bus.halted, strobes());
      end
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_rtype();
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_I, 1, 0, 1'b1);
  endtask

  task automatic test_load_wait();
    run_instr(OP_LOAD, 0, 2, 1'b0);
    run_instr(OP_STORE, 0, 1, 1'b1);
  endtask

  task automatic test_branch();
    run_instr(OP_BRANCH, 0, 0, 1'b0);
    run_instr(OP_BRANCH, 0, 0, 1'b1);
  endtask

  task automatic test_jal();
    run_instr(OP_JAL, 0, 0, 1'b1);
    run_instr(OP_JALR, 2, 0, 1'b0);
  endtask

  task automatic test_ecall();
    bus.opcode = OP_ECALL;
    bus.mem_ready = 1'b1;
    bus.alu_bcond = 1'b0;
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++;
    if ({bus.state, bus.halted, bus0.state} !== {ST_HALT, 1'b1, ST_EX}) begin
      errors++;
      $display("FAIL ecall_enter: got halt-dut state=%0d halted=%b nop-dut state=%0d expected 6 1 2",
               bus.state, bus.halted, bus0.state);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({bus0.state, bus0.inst_done, bus0.pc_write, bus0.reg_write, bus0.pc_source} !== {ST_WB, 4'b1100}) begin
      errors++;
      $display("FAIL ecall_nop_wb: got state=%0d done,pcw,rw,pcsrc=%b expected 5 1100", bus0.state,
               {bus0.inst_done, bus0.pc_write, bus0.reg_write, bus0.pc_source});
    end
    for (int i = 0; i < 11; i++) begin
      bus.opcode = 7'($urandom);
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.alu_bcond = 1'($urandom_range(0, 1));
      next_cycle();
      @(negedge clk);
      checks++;
      if ({bus.state, bus.halted, strobes()} !== {ST_HALT, 1'b1, 13'd0}) begin
        errors++;
        $display("FAIL halt_hold cyc=%0d: got state=%0d halted=%b strobes=%b expected 6 1 0",
                 i, bus.state, bus.halted, strobes());
      end
    end
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.halted, bus0.state} !== {ST_IF, 1'b0, ST_IF}) begin
      errors++;
      $display("FAIL halt_reset: got state=%0d halted=%b nop-dut state=%0d expected 0 0 0",
               bus.state, bus.halted, bus0.state);
    end
    next_cycle();
  endtask

  task automatic test_store_reset();
    bus.opcode = OP_STORE;
    bus.mem_ready = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.mem_write, bus.i_or_d} !== {ST_MEM, 2'b11}) begin
      errors++;
      $display("FAIL store_wait: got state=%0d mem_write,i_or_d=%b expected 4 11", bus.state,
               {bus.mem_write, bus.i_or_d});
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes() !== 13'd0) begin
      errors++;
      $display("FAIL store_reset_strobes: got %b expected 0", strobes());
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.inst_done} !== {ST_IF, 1'b0}) begin
      errors++;
      $display("FAIL store_reset_next: got state=%0d inst_done=%b expected 0 0", bus.state, bus.inst_done);
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, 7'h7F, 7'h00};
    for (int t = 0; t < 40; t++)
      run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
  endtask

  initial begin
    bus.opcode = 7'd0;
    bus.alu_bcond = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_jal();
    test_ecall();
    test_store_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
